// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes ordered {a,b,c,d,e,f,g}
// and the display-value record used by multiplexed display blocks.
package seg7_pkg;

  typedef logic [6:0] seg_t;   // bit 6 = a ... bit 0 = g, 0 = lit

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_DASH  = 7'b1111110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } disp_val_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to active-low segment encoder; non-decimal nibbles
// show a dash, and the blank flag overrides everything.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  // NOTE: seg_o gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a double-buffered input value
// that is only committed at frame boundaries, inter-digit blanking and zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_en,
  input  logic        lz_en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_bcd,
  input  logic [3:0]  in_dp,
  output logic        led_a,
  output logic        led_b,
  output logic        led_c,
  output logic        led_d,
  output logic        led_e,
  output logic        led_f,
  output logic        led_g,
  output logic        led_dp,
  output logic [3:0]  dig_en
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  disp_val_t        act_q, act_d, pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  seg_t             seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       dig_en_q, dig_en_d;

  logic       slot_end, frame_end, accept, drive, suppress;
  logic [3:0] cur_nib;
  seg_t       seg_drv;

  assign in_ready  = !pend_vld_q;
  assign accept    = in_valid && !pend_vld_q;
  assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end = disp_en && slot_end && (idx_q == 2'd3);

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (disp_en) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Accept needs an empty buffer and commit needs a full one, so they never overlap.
    if (accept) begin
      pend_d     = '{bcd: in_bcd, dp: in_dp};
      pend_vld_d = 1'b1;
    end else if (frame_end && pend_vld_q) begin
      act_d      = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  // Digit k is a leading zero when the value shifted down by k nibbles is zero.
  assign cur_nib  = act_q.bcd[{idx_q, 2'b00} +: 4];
  assign suppress = lz_en && (idx_q != 2'd0) && ((act_q.bcd >> {idx_q, 2'b00}) == 16'd0);
  assign drive    = disp_en && (cnt_q >= CNT_W'(BLANK_CYC));

  seg7_encode u_encode (
    .nibble_i (cur_nib),
    .blank_i  (suppress),
    .seg_o    (seg_drv)
  );

  always_comb begin
    seg_d    = SEG_BLANK;
    dp_d     = 1'b1;
    dig_en_d = 4'b1111;
    if (drive) begin
      seg_d    = seg_drv;
      dp_d     = !(act_q.dp[idx_q] && !suppress);
      dig_en_d = ~(4'b0001 << idx_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      dig_en_q   <= 4'b1111;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_en_q   <= dig_en_d;
    end
  end

  assign {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = seg_q;
  assign led_dp = dp_q;
  assign dig_en = dig_en_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display, driving the same active-low `led_a`..`led_g` segment lines as the single-digit counter display. Accepts a 4-digit BCD value over a valid/ready handshake and double-buffers it. It cycles the digit enables, blanks between digits to prevent ghosting, and optionally suppresses leading zeros. A new value is committed only at frame boundaries so a frame never mixes old and new digits.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 4.
- `BLANK_CYC`, default 500: dead-time cycles at the start of each slot; legal range 1 to `SCAN_DIV`-2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `disp_en`  in  1  1 = scan normally; 0 = all digits off, scan counters held.
- `lz_en`  in  1  1 = suppress leading zeros.
- `in_valid`  in  1  new display value offered.
- `in_ready`  out  1  controller can accept a value.
- `in_bcd`  in  16  four nibbles; [3:0] is digit 0 (rightmost).
- `in_dp`  in  4  decimal point per digit; 1 = on.
- `led_a`..`led_g`  out  1 each  segment lines, active-low.
- `led_dp`  out  1  decimal point line, active-low.
- `dig_en`  out  4  digit anode enables, active-low; at most one bit low.

## Operation
- Registers: `act` (16-bit value + 4-bit dp), `pend` (same), `pend_vld`, slot counter `cnt` (0..`SCAN_DIV`-1), digit index `idx` (0..3).
- Handshake: `in_ready` = !`pend_vld`. When `in_valid && in_ready`, `pend` captures `in_bcd`/`in_dp` and `pend_vld` is set. `in_valid` without `in_ready` is ignored; the source must hold it.
- Frame boundary: the edge on which `idx` wraps 3→0. If `pend_vld` was set before that edge, copy `pend` to `act` and clear `pend_vld`. A capture and a boundary cannot coincide: capture needs `pend_vld`=0, and commit needs `pend_vld`=1.
- Slot phases: BLANK while `cnt` < `BLANK_CYC`, meaning `dig_en`=4'b1111 and all segments 1. DRIVE otherwise, meaning `dig_en[idx]`=0 and the segments carry the encoding of `act` nibble `idx`.
- Encoding of {a,b,c,d,e,f,g}, where 0 = segment lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - nibbles A–F = 1111110 (dash)
  - blank = 1111111
- Leading-zero suppression, when `lz_en`=1: digit k (k=3..1) is blanked if nibbles k..3 are all 0. Digit 0 is never suppressed. A suppressed digit also has `led_dp`=1.
- `disp_en`=0: outputs go blank and `cnt`/`idx` hold. The handshake still accepts into `pend`, but no commit happens because there is no boundary. When `disp_en` returns to 1, scanning resumes from the held `cnt`/`idx`.
- Reset mid-operation discards `pend` and `act` in the same cycle.

## Timing
- Reset values, visible after the reset edge: `led_a`..`led_g`=1, `led_dp`=1, `dig_en`=4'b1111, `in_ready`=1, `act`=0 with dp=0, `pend_vld`=0, `cnt`=0, `idx`=0.
- Outputs are registered and computed from the current `cnt`/`idx`/`act`, so they lag the internal state by 1 cycle. `dig_en` and the segment lines change on the same edge.
- `cnt` wraps at `SCAN_DIV`-1, and `idx` increments mod 4 on that edge. Frame period is 4×`SCAN_DIV` cycles.
- `in_ready` drops the cycle after an accept. It rises the cycle after the commit edge.
- Latency from accept to first display: up to one frame plus one cycle. The committed value first appears in the digit-0 slot.

## Structure
- Shared package `seg7_pkg`: the ten digit codes, the DASH and BLANK constants, and the segment-vector ordering {a..g}.
- Sub-module `seg7_encode`: combinational nibble plus blank flag to 7-bit active-low segments, reusable by other display blocks.
- The top level contains the counters, the double buffer and the output registers.

## Test plan
All scenarios use `SCAN_DIV`=8, `BLANK_CYC`=2.
- Reset → all outputs match the reset values, `in_ready`=1. The first frame shows "0000" (`lz_en`=0), with `dig_en` low only at `cnt` 2..7 of each slot.
- Accept 16'h1234, dp=4'b0100 → `act` commits at the next 3→0 wrap. Digit 0 then shows 1001100 (4), and digit 2 shows 0010010 with `led_dp`=0. `in_ready` is low from accept through commit.
- With `pend_vld`=1, present 16'h5678 → not accepted. After the commit, hold `in_valid` → it is accepted on the first `in_ready`=1 cycle.
- `lz_en`=1 with 16'h0050 → digits 3 and 2 stay blank with `dig_en` still low in their slots, digit 1 shows 5, digit 0 shows 0. Also check 16'h0000 → only digit 0 lit.
- 16'h00AF → digits 1 and 0 show 1111110. Toggle `disp_en`=0 mid-slot → `dig_en`=1111 and `cnt`/`idx` hold. Re-enable → the slot resumes at the held `cnt`.
- Assert `rst` with `pend_vld`=1 mid-DRIVE → next cycle all outputs are at their reset values and the pending value is never displayed.
